flow_ctrl: RTL and testbench

Sequencer for the program counter. Each cycle it decides whether the PC increments, holds, or takes an absolute jump, and drives the PC's `absjump_en`/`target` pair. It resolves jumps, conditional branches, call/return, halt and memory stalls. It owns a programmable 16-entry jump-target LUT and a return-address stack, and sits between the instruction decoder and the PC.

---
 rtl/flow_ctrl.sv | 106 ++++++++++
 tb/tb_flow_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/flow_ctrl.sv
// flow_ctrl: PC sequencer resolving jumps, branches, call/return, halt and stalls via a jump LUT and return stack
module flow_ctrl #(
  parameter int D  = 9,
  parameter int SD = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [D:0]                pc,
  input  logic                      start,
  input  logic                      stall_req,
  input  logic                      op_jmp,
  input  logic                      op_br,
  input  logic                      op_call,
  input  logic                      op_ret,
  input  logic                      op_halt,
  input  logic [3:0]                lut_idx,
  input  logic                      cond_flag,
  input  logic                      lut_wr_en,
  input  logic [3:0]                lut_wr_addr,
  input  logic [D:0]                lut_wr_data,
  output logic                      absjump_en,
  output logic [D:0]                target,
  output logic                      halted,
  output logic                      stack_err,
  output logic [$clog2(SD+1)-1:0]   sp
);
  localparam int SW = $clog2(SD + 1);
  localparam int AW = SD > 1 ? $clog2(SD) : 1;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, nxt;
  logic [D:0] lut [16];
  logic [D:0] stk [SD];
  logic [D:0] lut_q, tos;
  logic push, pop, err, clr;
  assign lut_q = lut[lut_idx];
  assign tos   = stk[AW'(sp - 1'b1)];
  always_comb begin
    absjump_en = 1'b1;
    target     = pc;
    nxt        = state;
    push       = 1'b0;
    pop        = 1'b0;
    err        = 1'b0;
    clr        = 1'b0;
    if (!reset) begin
      if (state == IDLE) begin
        if (start) nxt = RUN;
      end else if (state == HALT) begin
        if (start) begin
          target = '0;
          clr    = 1'b1;
          nxt    = RUN;
        end
      end else if (!stall_req) begin
        if (op_halt) nxt = HALT;
        else if (op_ret) begin
          if (sp == '0) begin
            err = 1'b1;
            nxt = HALT;
          end else begin
            target = tos;
            pop    = 1'b1;
          end
        end else if (op_call) begin
          if (sp == SW'(SD)) begin
            err = 1'b1;
            nxt = HALT;
          end else begin
            target = lut_q;
            push   = 1'b1;
          end
        end else if (op_jmp || (op_br && cond_flag)) target = lut_q;
        else begin
          absjump_en = 1'b0;
          target     = '0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sp        <= '0;
      stack_err <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state  <= nxt;
      halted <= nxt == HALT;
      if (clr) begin
        sp        <= '0;
        stack_err <= 1'b0;
      end else begin
        sp        <= sp + SW'(push) - SW'(pop);
        stack_err <= stack_err | err;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < 16; i++) lut[i] <= '0;
    else if (lut_wr_en) lut[lut_wr_addr] <= lut_wr_data;
  end
  // stack contents survive reset; only sp is cleared
  always_ff @(posedge clk) begin
    if (push) stk[AW'(sp)] <= pc + 1'b1;
  end
endmodule

// File: tb/tb_flow_ctrl.sv
// tb_flow_ctrl: directed checks of flow_ctrl driving a modelled PC register
module tb_flow_ctrl;
  logic clk = 0, reset = 1;
  logic start = 0, stall_req = 0, op_jmp = 0, op_br = 0, op_call = 0, op_ret = 0, op_halt = 0;
  logic [3:0] lut_idx = 0, lut_wr_addr = 0;
  logic cond_flag = 0, lut_wr_en = 0;
  logic [9:0] lut_wr_data = 0;
  logic absjump_en, halted, stack_err;
  logic [9:0] target, pc, pc_q, ld_val = 0;
  logic ld = 0;
  logic [2:0] sp;
  int tests = 0, fails = 0;

  flow_ctrl dut (
    .clk(clk), .reset(reset), .pc(pc), .start(start), .stall_req(stall_req),
    .op_jmp(op_jmp), .op_br(op_br), .op_call(op_call), .op_ret(op_ret), .op_halt(op_halt),
    .lut_idx(lut_idx), .cond_flag(cond_flag), .lut_wr_en(lut_wr_en),
    .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data), .absjump_en(absjump_en),
    .target(target), .halted(halted), .stack_err(stack_err), .sp(sp)
  );

  always #5 clk = ~clk;
  assign pc = ld ? ld_val : pc_q;
  always @(posedge clk) pc_q <= reset ? 10'd0 : (absjump_en ? target : pc + 10'd1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ops(input logic j, b, c, r, h, input logic [3:0] idx);
    {op_jmp, op_br, op_call, op_ret, op_halt} = {j, b, c, r, h};
    lut_idx = idx;
  endtask

  initial begin
    tick(); tick();
    chk("rst_halted", halted, 0);
    chk("rst_err", stack_err, 0);
    chk("rst_sp", sp, 0);
    ld = 1; ld_val = 10'h155; #1;
    chk("rst_aj", absjump_en, 1);
    chk("rst_tgt", target, 10'h155);
    ld = 0;
    reset = 0;
    tick(); chk("idle_c1", pc_q, 0);
    tick(); chk("idle_c2", pc_q, 0);
    start = 1;
    tick(); chk("start_c3", pc_q, 0);
    start = 0;
    tick(); chk("run_c4", pc_q, 1);
    // jump and branch
    lut_wr_en = 1; lut_wr_addr = 5; lut_wr_data = 10'h120; tick();
    lut_wr_addr = 6; lut_wr_data = 10'h200; tick();
    lut_wr_addr = 7; lut_wr_data = 10'h300; tick();
    lut_wr_en = 0;
    ld = 1; ld_val = 10'h010; ops(1, 0, 0, 0, 0, 5); #1;
    chk("jmp_tgt", target, 10'h120);
    tick(); ld = 0;
    chk("jmp_pc", pc_q, 10'h120);
    ops(0, 1, 0, 0, 0, 5); cond_flag = 0; #1;
    chk("br0_aj", absjump_en, 0);
    chk("br0_tgt", target, 0);
    tick(); chk("br0_pc", pc_q, 10'h121);
    ld = 1; ld_val = 10'h120; cond_flag = 1;
    tick(); ld = 0; cond_flag = 0;
    chk("br1_pc", pc_q, 10'h120);
    // nested calls and returns
    ld = 1; ld_val = 10'h004; ops(0, 0, 1, 0, 0, 5);
    tick(); ld = 0;
    chk("call1_pc", pc_q, 10'h120); chk("call1_sp", sp, 1);
    lut_idx = 6; tick(); chk("call2_pc", pc_q, 10'h200); chk("call2_sp", sp, 2);
    lut_idx = 7; tick(); chk("call3_pc", pc_q, 10'h300); chk("call3_sp", sp, 3);
    ops(0, 0, 0, 1, 0, 0);
    tick(); chk("ret1_pc", pc_q, 10'h201); chk("ret1_sp", sp, 2);
    tick(); chk("ret2_pc", pc_q, 10'h121); chk("ret2_sp", sp, 1);
    tick(); chk("ret3_pc", pc_q, 10'h005); chk("ret3_sp", sp, 0);
    // overflow
    ld = 1; ld_val = 10'h300; ops(0, 0, 1, 0, 0, 7);
    tick(); tick(); tick(); tick();
    chk("fill_sp", sp, 4);
    chk("fill_err", stack_err, 0);
    #1;
    chk("ovf_aj", absjump_en, 1);
    chk("ovf_tgt", target, 10'h300);
    tick(); ld = 0;
    chk("ovf_pc", pc_q, 10'h300); chk("ovf_sp", sp, 4);
    chk("ovf_err", stack_err, 1); chk("ovf_halted", halted, 1);
    ops(0, 0, 0, 0, 0, 0);
    tick(); chk("ovf_hold", pc_q, 10'h300);
    start = 1; #1;
    chk("restart_tgt", target, 0);
    tick(); start = 0;
    chk("restart_pc", pc_q, 0); chk("restart_sp", sp, 0);
    chk("restart_err", stack_err, 0); chk("restart_halted", halted, 0);
    // underflow
    ops(0, 0, 0, 1, 0, 0);
    tick(); ops(0, 0, 0, 0, 0, 0);
    chk("unf_pc", pc_q, 0); chk("unf_err", stack_err, 1);
    chk("unf_halted", halted, 1); chk("unf_sp", sp, 0);
    start = 1; tick(); start = 0;
    chk("unf_restart_err", stack_err, 0);
    // stall with a pending call and a LUT write
    ld = 1; ld_val = 10'h050; ops(0, 0, 1, 0, 0, 5); stall_req = 1;
    lut_wr_en = 1; lut_wr_addr = 8; lut_wr_data = 10'h0AA;
    for (int i = 0; i < 3; i++) begin
      tick(); lut_wr_en = 0;
      chk("stall_pc", pc_q, 10'h050); chk("stall_sp", sp, 0);
    end
    stall_req = 0;
    tick(); ld = 0;
    chk("stall_call_pc", pc_q, 10'h120); chk("stall_call_sp", sp, 1);
    ops(0, 0, 0, 1, 0, 0);
    tick(); chk("stall_ret_pc", pc_q, 10'h051);
    ops(1, 0, 0, 0, 0, 8);
    tick(); chk("stall_lutwr", pc_q, 10'h0AA);
    ops(0, 0, 0, 0, 0, 0); start = 1;
    tick(); start = 0;
    chk("start_in_run", pc_q, 10'h0AB);
    // halt
    ld = 1; ld_val = 10'h033; ops(0, 0, 0, 0, 1, 0);
    tick(); ld = 0; ops(1, 0, 0, 0, 0, 5);
    chk("halt_pc", pc_q, 10'h033); chk("halt_flag", halted, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("halt_frozen", pc_q, 10'h033); chk("halt_stay", halted, 1);
    end
    ops(0, 0, 0, 0, 0, 0); start = 1;
    tick(); start = 0;
    chk("halt_restart", pc_q, 0);
    // wrap of return address
    ld = 1; ld_val = 10'h3FF; ops(0, 0, 1, 0, 0, 5);
    tick(); ld = 0; chk("wrap_call_pc", pc_q, 10'h120);
    ops(0, 0, 0, 1, 0, 0); #1;
    chk("wrap_ret_tgt", target, 0);
    tick(); chk("wrap_ret_pc", pc_q, 0); chk("wrap_sp", sp, 0);
    // same-cycle LUT write/read
    ops(1, 0, 0, 0, 0, 5); lut_wr_en = 1; lut_wr_addr = 5; lut_wr_data = 10'h2AB; #1;
    chk("rw_old_tgt", target, 10'h120);
    tick(); lut_wr_en = 0;
    chk("rw_old_pc", pc_q, 10'h120);
    tick(); chk("rw_new_pc", pc_q, 10'h2AB);
    // reset mid-call
    ops(0, 0, 1, 0, 0, 5); reset = 1; #1;
    chk("rstcall_aj", absjump_en, 1);
    chk("rstcall_tgt", target, 10'h2AB);
    tick(); reset = 0; ops(0, 0, 0, 0, 0, 0);
    chk("rstcall_sp", sp, 0); chk("rstcall_pc", pc_q, 0);
    start = 1; tick(); start = 0;
    ops(1, 0, 0, 0, 0, 5); #1;
    chk("lut_cleared", target, 0);
    tick(); ops(0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
